// File: rtl/b_share_sched.sv
// rtl/b_share_sched.sv - sequencer time-sharing one B cell between up to four requesters
// Optional build macro: B_SHARE_SCHED_RR_EN (round-robin arbitration; fixed priority when undefined)
module b_share_sched #(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inout  wire                  VDD,
  inout  wire                  VSS,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic [3:0]           b_in,
  input  logic [3:0]           b_out,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_id,
  output logic [3:0]           rsp_data
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("b_share_sched: SETTLE_CYCLES must be at least 1");
  end
  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("b_share_sched: NUM_REQ must be in 2..4");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic [1:0]    cur_id;
  logic          win_found;
  logic [1:0]    win_idx;
  logic [3:0]    win_data;

  // Power pins only pass through this block; they carry no logic function.
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

`ifdef B_SHARE_SCHED_RR_EN
  logic [1:0] rr_ptr;

  // Round-robin pointer remembers the last winner; restarts at NUM_REQ-1 after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'(NUM_REQ - 1);
    end else if (state == IDLE && win_found) begin
      rr_ptr <= win_idx;
    end
  end

  // Arbiter: first requesting index found walking up from pointer+1, wrapping at NUM_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && req[i] && (i == (int'(rr_ptr) + 1 + k) % NUM_REQ)) begin
          win_found = 1'b1;
          win_idx   = 2'(i);
        end
      end
    end
  end
`else
  // Arbiter: fixed priority, lowest requesting index wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
      end
    end
  end
`endif

  // Operand mux: pick the winner's 4-bit slice of req_data
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == 2'(i)) begin
        win_data = req_data[4*i +: 4];
      end
    end
  end

  // Sequencer: grant and drive B, hold for the settle window, capture B into a tagged response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      cur_id     <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      b_in       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state  <= ISSUE;
            cur_id <= win_idx;
            b_in   <= win_data;
            gnt    <= NUM_REQ'(1) << win_idx;
            busy   <= 1'b1;
          end
        end
        ISSUE: begin
          state      <= WAIT;
          settle_cnt <= SETTLE_LOAD;
        end
        WAIT: begin
          if (settle_cnt == '0) begin
            state     <= CAPTURE;
            rsp_data  <= b_out;
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        CAPTURE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_b_share_sched.sv
// tb/tb_b_share_sched.sv - directed self-checking bench for b_share_sched (NUM_REQ=4, SETTLE_CYCLES=2)
module tb_b_share_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  wire         vdd;
  wire         vss;
  logic [3:0]  req = '0;
  logic [15:0] req_data = '0;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  b_in;
  logic [3:0]  b_out;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  // B cell model: inverts its inputs
  assign b_out = b_in ^ 4'hF;

  always #5 clk = ~clk;

  b_share_sched #(.NUM_REQ(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .VDD(vdd), .VSS(vss),
    .req(req), .req_data(req_data), .gnt(gnt), .busy(busy),
    .b_in(b_in), .b_out(b_out), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  // Runs one transaction from cycle 0 (caller is at a negedge) and records what happened
  task automatic do_txn(input logic [3:0] r, output logic [3:0] g, output int gcyc,
                        output logic [1:0] rid, output logic [3:0] rdat, output int rcyc);
    g = '0; gcyc = -1; rid = '0; rdat = '0; rcyc = -1;
    req = r;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (gnt !== 4'b0000 && gcyc < 0) begin
        g = gnt; gcyc = c; req = '0;
      end
      if (rsp_valid === 1'b1 && rcyc < 0) begin
        rid = rsp_id; rdat = rsp_data; rcyc = c;
      end
    end
    req = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = '0; req_data = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({gnt, busy, b_in, rsp_valid, rsp_id, rsp_data} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0000", {gnt, busy, b_in, rsp_valid, rsp_id, rsp_data});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_single;
    req_data = 16'h000A; req = 4'b0001;
    @(negedge clk); // cycle 1
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b required 0001", gnt); end
    n_checks++; if (b_in !== 4'hA) begin n_fail++; $display("FAIL single_b_in: got %h required a", b_in); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_issue: got %b required 1", busy); end
    req = '0;
    @(negedge clk); // cycle 2
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_width: got %b required 0000", gnt); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_early2: got %b required 0", rsp_valid); end
    @(negedge clk); // cycle 3
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_early3: got %b required 0", rsp_valid); end
    @(negedge clk); // cycle 4
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b required 1", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_rsp_id: got %0d required 0", rsp_id); end
    n_checks++; if (rsp_data !== 4'h5) begin n_fail++; $display("FAIL single_rsp_data: got %h required 5", rsp_data); end
    @(negedge clk); // cycle 5
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_width: got %b required 0", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b required 0", busy); end
    n_checks++; if (b_in !== 4'hA) begin n_fail++; $display("FAIL single_b_in_hold: got %h required a", b_in); end
  endtask

  task automatic test_back_to_back;
    int exp_ord[5];
    logic [3:0] exp_dat[5];
    int ng = 0;
    int nr = 0;
`ifdef B_SHARE_SCHED_RR_EN
    exp_ord = '{0, 1, 2, 3, 0};
    exp_dat = '{4'hE, 4'hD, 4'hC, 4'hB, 4'hE};
`else
    exp_ord = '{0, 0, 0, 0, 0};
    exp_dat = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hE};
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_data = 16'h4321; req = 4'b1111;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      n_checks++;
      if (gnt !== 4'b0000 && rsp_valid === 1'b1) begin
        n_fail++; $display("FAIL b2b_exclusive: cycle %0d gnt %b with rsp_valid 1", c, gnt);
      end
      if (gnt !== 4'b0000) begin
        n_checks++;
        if (ng >= 5) begin
          n_fail++; $display("FAIL b2b_extra_gnt: cycle %0d got %b required none", c, gnt);
        end else begin
          if (gnt !== (4'b0001 << exp_ord[ng]) || c != 1 + 5*ng) begin
            n_fail++; $display("FAIL b2b_gnt%0d: got %b at cycle %0d required %b at cycle %0d",
                               ng, gnt, c, 4'b0001 << exp_ord[ng], 1 + 5*ng);
          end
        end
        ng++;
      end
      if (rsp_valid === 1'b1) begin
        n_checks++;
        if (nr >= 5) begin
          n_fail++; $display("FAIL b2b_extra_rsp: cycle %0d", c);
        end else begin
          if (rsp_id !== 2'(exp_ord[nr]) || rsp_data !== exp_dat[nr] || c != 4 + 5*nr) begin
            n_fail++; $display("FAIL b2b_rsp%0d: got id %0d data %h cycle %0d required id %0d data %h cycle %0d",
                               nr, rsp_id, rsp_data, c, exp_ord[nr], exp_dat[nr], 4 + 5*nr);
          end
        end
        nr++;
      end
    end
    req = '0;
    n_checks++; if (ng != 5) begin n_fail++; $display("FAIL b2b_gnt_count: got %0d required 5", ng); end
    n_checks++; if (nr != 5) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d required 5", nr); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap;
    logic [3:0] g; int gc; logic [1:0] rid; logic [3:0] rd; int rc;
    logic [3:0] exp_g3;
`ifdef B_SHARE_SCHED_RR_EN
    exp_g3 = 4'b1000;
`else
    exp_g3 = 4'b0001;
`endif
    req_data = 16'h4321;
    do_txn(4'b1000, g, gc, rid, rd, rc);
    n_checks++; if (g !== 4'b1000 || gc != 1) begin n_fail++; $display("FAIL wrap_gnt3: got %b at %0d required 1000 at 1", g, gc); end
    n_checks++; if (rid !== 2'd3 || rd !== 4'hB || rc != 4) begin n_fail++; $display("FAIL wrap_rsp3: got id %0d data %h cycle %0d required 3 b 4", rid, rd, rc); end
    do_txn(4'b1001, g, gc, rid, rd, rc);
    n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL wrap_gnt0: got %b required 0001", g); end
    n_checks++; if (rid !== 2'd0 || rd !== 4'hE) begin n_fail++; $display("FAIL wrap_rsp0: got id %0d data %h required 0 e", rid, rd); end
    do_txn(4'b1001, g, gc, rid, rd, rc);
    n_checks++; if (g !== exp_g3) begin n_fail++; $display("FAIL wrap_gnt_next: got %b required %b", g, exp_g3); end
  endtask

  task automatic test_reset_mid;
    logic [3:0] g; int gc; logic [1:0] rid; logic [3:0] rd; int rc;
    req_data = 16'h4321; req = 4'b0010;
    @(negedge clk); // cycle 1
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rstmid_gnt1: got %b required 0010", gnt); end
    req = '0;
    @(negedge clk); // cycle 2, WAIT
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt, busy, b_in, rsp_valid, rsp_id, rsp_data} !== 16'h0000) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h required 0000", {gnt, busy, b_in, rsp_valid, rsp_id, rsp_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_quiet: cycle %0d rsp_valid %b busy %b required 0 0", c, rsp_valid, busy);
      end
    end
    do_txn(4'b1111, g, gc, rid, rd, rc);
    n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL rstmid_next_gnt: got %b required 0001", g); end
  endtask

  task automatic test_hold;
    req_data = 16'h0600; req = 4'b0100;
    @(negedge clk); // cycle 1
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL hold_gnt: got %b required 0100", gnt); end
    n_checks++; if (b_in !== 4'h6) begin n_fail++; $display("FAIL hold_b_in1: got %h required 6", b_in); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy1: got %b required 1", busy); end
    @(negedge clk); // cycle 2, WAIT
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy2: got %b required 1", busy); end
    req = '0; req_data = 16'h3333;
    @(negedge clk); // cycle 3
    n_checks++; if (b_in !== 4'h6) begin n_fail++; $display("FAIL hold_b_in3: got %h required 6", b_in); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy3: got %b required 1", busy); end
    @(negedge clk); // cycle 4, CAPTURE
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL hold_rsp_valid: got %b required 1", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL hold_rsp_id: got %0d required 2", rsp_id); end
    n_checks++; if (rsp_data !== 4'h9) begin n_fail++; $display("FAIL hold_rsp_data: got %h required 9", rsp_data); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy4: got %b required 1", busy); end
    @(negedge clk); // cycle 5, IDLE
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_busy5: got %b required 0", busy); end
    n_checks++; if (b_in !== 4'h6) begin n_fail++; $display("FAIL hold_b_in5: got %h required 6", b_in); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL hold_no_regrant: got %b required 0000", gnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/b_share_sched.md
# b_share_sched

Sequencing controller that time-shares one instance of the B cell between up to four requesters. It latches a granted requester's 4-bit operand onto B's four inputs, waits a programmable settle window covering B's delay-cell path, and captures B's four outputs into a tagged response. It sits beside the B instance inside A-level wrappers, carrying the same power pins as the surrounding netlist.

## Interface
- NUM_REQ, 4: number of requesters, 2..4
- SETTLE_CYCLES, 2: cycles B inputs are held before outputs are sampled; minimum 1, 0 illegal
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- VDD  inout  1  power, pass-through
- VSS  inout  1  ground, pass-through
- req  input  NUM_REQ  per-requester request level
- req_data  input  4*NUM_REQ  operand of requester i at [4i+3:4i]
- gnt  output  NUM_REQ  one-hot grant pulse
- busy  output  1  high in every state except IDLE
- b_in  output  4  to B: bit0 in_B_one, bit1 in_B_two, bit2 in_B_three, bit3 in_B_four
- b_out  input  4  from B: bit0 out_B_one, bit1 out_B_two, bit2 out_B_three, bit3 out_B
- rsp_valid  output  1  one-cycle response pulse
- rsp_id  output  2  index of the serviced requester
- rsp_data  output  4  captured b_out

## Operation
- States: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE: if any req bit is high, arbitrate, register winner index and its req_data slice, go to ISSUE; otherwise stay.
- ISSUE (1 cycle): gnt[winner]=1; b_in drives the registered operand; go to WAIT with settle counter = SETTLE_CYCLES-1.
- WAIT: b_in held; counter decrements; at 0 go to CAPTURE. b_out is registered on the clock edge leaving WAIT.
- CAPTURE (1 cycle): rsp_valid=1, rsp_id=winner, rsp_data=registered b_out; go to IDLE.
- b_in keeps its last operand after the transaction (no return to 0), so B inputs toggle only on ISSUE.
- Requesters hold req until they see gnt; a req dropped before IDLE arbitration is not selected. req changes after arbitration do not affect the transaction in flight.
- Request bits at index >= NUM_REQ are ignored.
- Reset values: gnt=0, busy=0, b_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, state IDLE, arbitration pointer=NUM_REQ-1.
- Reset asserted mid-transaction: all outputs return to reset values immediately; no rsp_valid for the aborted transaction; after release the pointer restarts as from power-up.

## Timing
- Request seen in IDLE at cycle 0: gnt and new b_in at cycle 1; rsp_valid at cycle SETTLE_CYCLES+2; IDLE at cycle SETTLE_CYCLES+3.
- Throughput: one transaction per SETTLE_CYCLES+3 cycles under continuous request; next gnt at the earliest in cycle SETTLE_CYCLES+4.
- gnt and rsp_valid never assert in the same cycle; each is exactly one cycle wide.
- B is combinational from b_in to b_out; SETTLE_CYCLES sets the multicycle budget.

## Configuration
- B_SHARE_SCHED_RR_EN defined: round-robin; search starts at pointer+1 modulo NUM_REQ, pointer updated to the winner at each grant.
- Not defined: fixed priority, lowest index wins; pointer logic not built.

## Test plan
- Reset then req=4'b0001, req_data[3:0]=4'hA, b_out modelled as b_in ^ 4'hF, SETTLE_CYCLES=2 -> gnt=4'b0001 at cycle 1, b_in=4'hA, rsp_valid at cycle 4 with rsp_id=0, rsp_data=4'h5.
- req=4'b1111 held continuously with RR_EN -> grant order 0,1,2,3,0 with gnts spaced 5 cycles; without RR_EN -> gnt[0] every transaction.
- Grant on requester 3 with RR_EN, then req=4'b1001 -> next gnt is requester 0 (pointer wraps).
- rst_n pulsed low during WAIT -> b_in, busy, gnt, rsp_* read 0 immediately; no rsp_valid after release; next grant goes to requester 0.
- req_data changed and req dropped during WAIT -> b_in and rsp_data reflect the operand latched in IDLE; busy=1 from ISSUE through CAPTURE, 0 in IDLE.
